hdmi_pattern_gen: RTL and testbench

Pixel-domain test-pattern source that drives the `rgb` input of the `hdmi` core from its `cx`/`cy` coordinate outputs. It offers four animated patterns:
- scrolling gradient
- 8-way colour bars
- scrolling checkerboard
- cycling solid colour

A frame counter and mode register update only during vertical blanking, so a frame never tears. Patterns are chosen either directly or by automatic rotation every N frames.

---
 rtl/hdmi_pattern_gen.sv | 146 ++++++++++++++
 tb/tb_hdmi_pattern_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: pixel-domain test-pattern source for the hdmi core.
// Draws one of four animated patterns from the cx/cy raster position. The
// frame counter and mode only change at the start of vertical blanking, so
// a frame never shows two different pattern states.
module hdmi_pattern_gen #(
    parameter int BIT_WIDTH       = 10,
    parameter int BIT_HEIGHT      = 10,
    parameter int SCREEN_WIDTH    = 720,
    parameter int SCREEN_HEIGHT   = 480,
    parameter int FRAMES_PER_MODE = 120,
    parameter int CHECK_LOG2      = 5
) (
    input  logic                  clk_pixel,
    input  logic                  RST,
    input  logic [BIT_WIDTH-1:0]  cx,
    input  logic [BIT_HEIGHT-1:0] cy,
    input  logic [1:0]            mode_sel,
    input  logic                  auto_cycle,
    output logic [23:0]           rgb,
    output logic [1:0]            mode_active,
    output logic                  frame_tick
);

    typedef enum logic [1:0] {
        MODE_GRADIENT = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_SOLID    = 2'd3
    } mode_e;

    // A dwell of one frame still needs a one-bit counter.
    localparam int DWELL_W = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(FRAMES_PER_MODE - 1);

    // Standard 8-bar palette, shared by the bars and solid patterns.
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] col;
        case (idx)
            3'd0:    col = 24'hFFFFFF;
            3'd1:    col = 24'hFFFF00;
            3'd2:    col = 24'h00FFFF;
            3'd3:    col = 24'h00FF00;
            3'd4:    col = 24'hFF00FF;
            3'd5:    col = 24'hFF0000;
            3'd6:    col = 24'h0000FF;
            default: col = 24'h000000;
        endcase
        return col;
    endfunction

    logic                  fu_q, fu_d;
    logic [1:0]            sel_q, sel_d;
    logic                  auto_q, auto_d;
    logic [7:0]            frame_count_q, frame_count_d;
    mode_e                 mode_q, mode_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;
    logic                  tick_q, tick_d;
    logic [23:0]           rgb_q, rgb_d;

    logic                  fu_now;
    logic                  active;
    logic [2:0]            bar_idx;
    logic [BIT_WIDTH:0]    check_sum;
    logic                  check_sel;

    assign fu_now = (cx == '0) && (cy == BIT_HEIGHT'(SCREEN_HEIGHT));
    assign active = (cx < BIT_WIDTH'(SCREEN_WIDTH)) && (cy < BIT_HEIGHT'(SCREEN_HEIGHT));

    // Frame-update pipeline: capture the request on the FU cycle, apply it one cycle later.
    always_comb begin
        fu_d          = fu_now;
        sel_d         = sel_q;
        auto_d        = auto_q;
        frame_count_d = frame_count_q;
        mode_d        = mode_q;
        dwell_d       = dwell_q;
        tick_d        = fu_q;
        if (fu_now) begin
            sel_d  = mode_sel;
            auto_d = auto_cycle;
        end
        if (fu_q) begin
            frame_count_d = frame_count_q + 8'd1;
            if (!auto_q) begin
                mode_d  = mode_e'(sel_q);
                dwell_d = '0;
            end else if (dwell_q == DWELL_LAST) begin
                mode_d  = mode_e'(mode_q + 2'd1);
                dwell_d = '0;
            end else begin
                dwell_d = dwell_q + DWELL_W'(1);
            end
        end
    end

    // Pixel colour for the coordinate presented this cycle, using pre-update pattern state.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (cx >= BIT_WIDTH'((k * SCREEN_WIDTH) / 8)) begin
                bar_idx = bar_idx + 3'd1;
            end
        end
        check_sum = (BIT_WIDTH+1)'(cx) + (BIT_WIDTH+1)'(frame_count_q);
        check_sel = check_sum[CHECK_LOG2] ^ cy[CHECK_LOG2];
        rgb_d     = 24'h000000;
        if (active) begin
            case (mode_q)
                MODE_GRADIENT: rgb_d = {cx[7:0] + frame_count_q,
                                        cy[7:0] + frame_count_q,
                                        cx[5:0], cx[5:4]};
                MODE_BARS:     rgb_d = bar_color(bar_idx);
                MODE_CHECKER:  rgb_d = check_sel ? 24'hFFFFFF : 24'h000000;
                default:       rgb_d = bar_color(frame_count_q[7:5]);
            endcase
        end
    end

    // State registers; reset wins over any frame update in the same cycle.
    always_ff @(posedge clk_pixel) begin
        if (!RST) begin
            fu_q          <= 1'b0;
            sel_q         <= 2'd0;
            auto_q        <= 1'b0;
            frame_count_q <= 8'd0;
            mode_q        <= MODE_GRADIENT;
            dwell_q       <= '0;
            tick_q        <= 1'b0;
            rgb_q         <= 24'h000000;
        end else begin
            fu_q          <= fu_d;
            sel_q         <= sel_d;
            auto_q        <= auto_d;
            frame_count_q <= frame_count_d;
            mode_q        <= mode_d;
            dwell_q       <= dwell_d;
            tick_q        <= tick_d;
            rgb_q         <= rgb_d;
        end
    end

    assign rgb         = rgb_q;
    assign mode_active = mode_q;
    assign frame_tick  = tick_q;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// tb_hdmi_pattern_gen: directed bench for hdmi_pattern_gen with a reference
// model and an expected-pixel queue (one-cycle rgb latency).
module tb_hdmi_pattern_gen;

    localparam int W   = 720;
    localparam int H   = 480;
    localparam int FPM = 2;

    logic        clk;
    logic        RST;
    logic [9:0]  cx;
    logic [9:0]  cy;
    logic [1:0]  mode_sel;
    logic        auto_cycle;
    logic [23:0] rgb;
    logic [1:0]  mode_active;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] exp_q[$];

    int m_f     = 0;
    int m_mode  = 0;
    int m_dwell = 0;
    int m_fu    = 0;
    int m_tick  = 0;
    int m_sel   = 0;
    int m_auto  = 0;

    hdmi_pattern_gen #(
        .BIT_WIDTH(10),
        .BIT_HEIGHT(10),
        .SCREEN_WIDTH(W),
        .SCREEN_HEIGHT(H),
        .FRAMES_PER_MODE(FPM),
        .CHECK_LOG2(5)
    ) dut (
        .clk_pixel(clk),
        .RST(RST),
        .cx(cx),
        .cy(cy),
        .mode_sel(mode_sel),
        .auto_cycle(auto_cycle),
        .rgb(rgb),
        .mode_active(mode_active),
        .frame_tick(frame_tick)
    );

    // Free-running pixel clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [23:0] palette(input int k);
        logic [23:0] t[8];
        t = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        return t[k];
    endfunction

    function automatic logic [23:0] model_rgb(input int x, input int y);
        int r, g, b, s;
        if (x >= W || y >= H) return 24'h0;
        case (m_mode)
            0: begin
                r = (x % 256 + m_f) % 256;
                g = (y % 256 + m_f) % 256;
                b = (x % 64) * 4 + (x % 64) / 16;
                return {r[7:0], g[7:0], b[7:0]};
            end
            1: return palette((x * 8) / W);
            2: begin
                s = (((x + m_f) / 32) % 2) ^ ((y / 32) % 2);
                return (s != 0) ? 24'hFFFFFF : 24'h000000;
            end
            default: return palette(m_f / 32);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [23:0] obs, input logic [23:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: drive coordinates, queue the expected pixel, advance the model, compare.
    task automatic applyStimulus(input int x, input int y, input bit use_exp, input logic [23:0] expv);
        logic [23:0] want;
        @(negedge clk);
        cx = 10'(x);
        cy = 10'(y);
        want = !RST ? 24'h0 : (use_exp ? expv : model_rgb(x, y));
        exp_q.push_back(want);
        @(posedge clk);
        if (!RST) begin
            m_f = 0; m_mode = 0; m_dwell = 0; m_fu = 0; m_tick = 0;
            m_sel = 0; m_auto = 0;
        end else begin
            m_tick = m_fu;
            if (m_fu != 0) begin
                m_f = (m_f + 1) % 256;
                if (m_auto == 0) begin
                    m_mode = m_sel; m_dwell = 0;
                end else if (m_dwell == FPM - 1) begin
                    m_mode = (m_mode + 1) % 4; m_dwell = 0;
                end else begin
                    m_dwell++;
                end
            end
            m_fu = (x == 0 && y == H) ? 1 : 0;
            if (m_fu != 0) begin
                m_sel  = int'(mode_sel);
                m_auto = int'(auto_cycle);
            end
        end
        #1;
        checkOutput("rgb", rgb, exp_q.pop_front());
        checkOutput("frame_tick", 24'(frame_tick), 24'(m_tick));
        checkOutput("mode_active", 24'(mode_active), 24'(m_mode));
    endtask

    task automatic pix(input int x, input int y, input logic [23:0] expv);
        applyStimulus(x, y, 1'b1, expv);
    endtask

    task automatic step(input int x, input int y);
        applyStimulus(x, y, 1'b0, 24'h0);
    endtask

    // Frame update plus the following blanking cycles; returns observed ticks.
    task automatic do_fu(output int ticks);
        ticks = 0;
        step(0, H);
        ticks += int'(frame_tick);
        step(1, H);
        ticks += int'(frame_tick);
        step(2, H);
        ticks += int'(frame_tick);
    endtask

    int ticks;
    int auto_seq[10] = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 1};

    // Directed sequence.
    initial begin
        RST = 1'b0; cx = '0; cy = '0; mode_sel = 2'd0; auto_cycle = 1'b0;

        $display("[TB] reset sweep");
        step(0, 0);
        step(5, 3);
        step(0, H);
        step(100, 40);
        checkOutput("reset_mode", 24'(mode_active), 24'h0);
        RST = 1'b1;
        pix(5, 3, 24'h050314);

        $display("[TB] gradient offset");
        repeat (3) do_fu(ticks);
        pix(5, 3, 24'h080614);
        pix(720, 10, 24'h0);
        step(64, 200);

        $display("[TB] colour bars");
        mode_sel = 2'd1;
        do_fu(ticks);
        checkOutput("bars_tick_count", 24'(ticks), 24'd1);
        mode_sel = 2'd3;
        pix(89, 5, 24'hFFFFFF);
        pix(90, 5, 24'hFFFF00);
        pix(450, 5, 24'hFF0000);
        pix(719, 5, 24'h000000);
        pix(200, 479, 24'h00FFFF);

        $display("[TB] frame counter wrap");
        mode_sel = 2'd0;
        repeat (252) do_fu(ticks);
        pix(5, 3, 24'h050314);

        $display("[TB] checker scroll");
        repeat (255) do_fu(ticks);
        mode_sel = 2'd2;
        do_fu(ticks);
        pix(31, 0, 24'h000000);
        pix(32, 0, 24'hFFFFFF);
        pix(32, 32, 24'h000000);
        do_fu(ticks);
        pix(31, 0, 24'hFFFFFF);
        step(100, 77);

        $display("[TB] solid colour");
        mode_sel = 2'd3;
        do_fu(ticks);
        pix(300, 300, 24'hFFFFFF);

        $display("[TB] auto cycle");
        mode_sel = 2'd0;
        do_fu(ticks);
        auto_cycle = 1'b1;
        for (int i = 0; i < 10; i++) begin
            do_fu(ticks);
            checkOutput("auto_tick_count", 24'(ticks), 24'd1);
            checkOutput("auto_mode", 24'(mode_active), 24'(auto_seq[i]));
            mode_sel = 2'(i);
            step(33, 17);
            step(400, 100);
        end

        $display("[TB] reset collides with frame update");
        RST = 1'b0;
        step(0, H);
        RST = 1'b1;
        step(1, H);
        checkOutput("collide_tick", 24'(frame_tick), 24'h0);
        checkOutput("collide_mode", 24'(mode_active), 24'h0);
        pix(5, 3, 24'h050314);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
